// File: rtl/multistage_priority_arbiter_if.sv
// multistage_priority_arbiter_if
//   Bundles the channel-side and output-side handshakes of
//   multistage_priority_arbiter.
//   slave  : arbiter side (consumes in_*, produces out_*)
//   master : environment side (drives in_* and out_ready)
// Signals:
//   in_valid  [NUM_CHANNELS]            per-channel word present
//   in_data   [NUM_CHANNELS*DATA_WIDTH] channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_ready  [NUM_CHANNELS]            one-hot grant acknowledge, or zero
//   out_valid                           output word present
//   out_data  [DATA_WIDTH]              selected word
//   out_idx   [IDX_WIDTH]               source channel of out_data
//   out_ready                           downstream accepts
interface multistage_priority_arbiter_if #(
  parameter int DATA_WIDTH   = 135,
  parameter int NUM_CHANNELS = 4
);
  localparam int IDX_WIDTH = ($clog2(NUM_CHANNELS) > 1) ? $clog2(NUM_CHANNELS) : 1;

  logic [NUM_CHANNELS-1:0]            in_valid;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] in_data;
  logic [NUM_CHANNELS-1:0]            in_ready;
  logic                               out_valid;
  logic [DATA_WIDTH-1:0]              out_data;
  logic [IDX_WIDTH-1:0]               out_idx;
  logic                               out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx
  );
endinterface

// File: rtl/multistage_priority_arbiter.sv
// multistage_priority_arbiter
//   Arbitrates among NUM_CHANNELS valid/ready channels and forwards the
//   winner through a PIPE_STAGES-deep bubble-collapsing register pipeline.
//   Backpressure from out_ready reaches in_ready combinationally.
//   Default selection: fixed priority, highest valid index wins.
//   Define MULTISTAGE_PRIORITY_ARBITER_ROUND_ROBIN_EN for round-robin
//   selection starting below the last granted index.
// Ports:
//   clk    clock
//   reset  asynchronous, active-high
//   bus    multistage_priority_arbiter_if.slave (channel + output handshakes)
module multistage_priority_arbiter #(
  parameter int DATA_WIDTH   = 135,
  parameter int NUM_CHANNELS = 4,
  parameter int PIPE_STAGES  = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  multistage_priority_arbiter_if.slave  bus
);
  localparam int IDX_WIDTH = ($clog2(NUM_CHANNELS) > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int unsigned NC   = NUM_CHANNELS;
  localparam int unsigned NS   = PIPE_STAGES;
  localparam int unsigned LAST = PIPE_STAGES - 1;

  logic [PIPE_STAGES-1:0] r_v;
  logic [IDX_WIDTH-1:0]   r_idx  [PIPE_STAGES];
  logic [DATA_WIDTH-1:0]  r_data [PIPE_STAGES];

  logic [PIPE_STAGES-1:0] w_load;
  logic                   w_any;
  logic [IDX_WIDTH-1:0]   w_grant;
  logic [DATA_WIDTH-1:0]  w_sel_data;

`ifdef MULTISTAGE_PRIORITY_ARBITER_ROUND_ROBIN_EN
  logic [IDX_WIDTH-1:0]   r_ptr;
`endif

  // A stage may load if it, or any stage after it, is empty, or if the
  // output drains; accumulated from the output end so no signal feeds itself.
  always_comb begin
    logic w_acc;
    w_load = '0;
    w_acc  = bus.out_ready;
    for (int unsigned k = 0; k < NS; k++) begin
      w_acc             = w_acc | ~r_v[LAST - k];
      w_load[LAST - k]  = w_acc;
    end
  end

  // Grant selection: later loop iterations override earlier ones, so the
  // last match in the scan order has the highest priority.
  always_comb begin
    w_any   = |bus.in_valid;
    w_grant = '0;
`ifdef MULTISTAGE_PRIORITY_ARBITER_ROUND_ROBIN_EN
    // Scan ptr, ptr+1, ..., ptr-1: ptr-1 ends up highest, ptr lowest.
    for (int unsigned k = 0; k < NC; k++) begin
      for (int unsigned i = 0; i < NC; i++) begin
        if (bus.in_valid[i] && (((32'(r_ptr) + k) % NC) == i))
          w_grant = IDX_WIDTH'(i);
      end
    end
`else
    for (int unsigned i = 0; i < NC; i++) begin
      if (bus.in_valid[i])
        w_grant = IDX_WIDTH'(i);
    end
`endif
  end

  always_comb begin
    w_sel_data = '0;
    for (int unsigned i = 0; i < NC; i++) begin
      if (w_grant == IDX_WIDTH'(i))
        w_sel_data = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    bus.in_ready = '0;
    if (!reset && w_load[0] && w_any) begin
      for (int unsigned i = 0; i < NC; i++) begin
        if (w_grant == IDX_WIDTH'(i))
          bus.in_ready[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v <= '0;
      for (int unsigned s = 0; s < NS; s++) begin
        r_idx[s]  <= '0;
        r_data[s] <= '0;
      end
    end else begin
      if (w_load[0]) begin
        r_v[0] <= w_any;
        if (w_any) begin
          r_idx[0]  <= w_grant;
          r_data[0] <= w_sel_data;
        end
      end
      for (int unsigned s = 1; s < NS; s++) begin
        if (w_load[s]) begin
          r_v[s]    <= r_v[s-1];
          r_idx[s]  <= r_idx[s-1];
          r_data[s] <= r_data[s-1];
        end
      end
    end
  end

`ifdef MULTISTAGE_PRIORITY_ARBITER_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_ptr <= '0;
    else if (w_load[0] && w_any)
      r_ptr <= w_grant;
  end
`endif

  assign bus.out_valid = r_v[LAST];
  assign bus.out_data  = r_data[LAST];
  assign bus.out_idx   = r_idx[LAST];
endmodule
